// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - two-stage immediate encoder: signed immediate to instruction-field bit placement
// S1 holds the request and its range check; S2 holds the placed field and error flag.
module imm_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_field,
  output logic        out_err,
  output logic [15:0] err_cnt,
  input  logic        err_clr
);

  localparam logic [2:0] FMT_SHAMT = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;

  logic        s1_valid;
  logic [2:0]  s1_fmt;
  logic [31:0] s1_imm;
  logic        s1_legal;
  logic        s2_adv;
  logic        in_legal;
  logic [31:0] s1_field;

  // One shared advance condition: S1 only moves when S2 can take it.
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  always_comb begin
    in_legal = 1'b0;
    case (in_fmt)
      FMT_SHAMT:    in_legal = (in_imm[31:5] == 27'd0);
      FMT_I, FMT_S: in_legal = (in_imm[31:11] == {21{in_imm[11]}});
      FMT_B:        in_legal = !in_imm[0] && (in_imm[31:12] == {20{in_imm[12]}});
      FMT_U:        in_legal = (in_imm[11:0] == 12'd0);
      FMT_J:        in_legal = !in_imm[0] && (in_imm[31:20] == {12{in_imm[20]}});
      default:      in_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_fmt   <= in_fmt;
      s1_imm   <= in_imm;
      s1_legal <= in_legal;
    end
  end

  // Illegal requests place nothing, so the field stays all-zero.
  always_comb begin
    s1_field = 32'd0;
    if (s1_legal) begin
      case (s1_fmt)
        FMT_SHAMT: s1_field[24:20] = s1_imm[4:0];
        FMT_I:     s1_field[31:20] = s1_imm[11:0];
        FMT_S: begin
          s1_field[31:25] = s1_imm[11:5];
          s1_field[11:7]  = s1_imm[4:0];
        end
        FMT_B: begin
          s1_field[31]    = s1_imm[12];
          s1_field[7]     = s1_imm[11];
          s1_field[30:25] = s1_imm[10:5];
          s1_field[11:8]  = s1_imm[4:1];
        end
        FMT_U:     s1_field[31:12] = s1_imm[31:12];
        FMT_J: begin
          s1_field[31]    = s1_imm[20];
          s1_field[30:21] = s1_imm[10:1];
          s1_field[20]    = s1_imm[11];
          s1_field[19:12] = s1_imm[19:12];
        end
        default:   s1_field = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_field <= 32'd0;
      out_err   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_field <= s1_field;
        out_err   <= !s1_legal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_cnt <= 16'd0;
    end else if (out_valid && out_ready && out_err && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_imm_pack.sv
// tb/tb_imm_pack.sv - directed self-checking bench for imm_pack
module tb_imm_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = 3'd0;
  logic [31:0] in_imm = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_field;
  logic        out_err;
  logic [15:0] err_cnt;
  logic        err_clr = 1'b0;

  int tests = 0;
  int fails = 0;

  imm_pack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_field(out_field), .out_err(out_err), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Single request into an empty pipeline with out_ready high; samples on falling edges.
  task automatic run_req(input logic [2:0] f, input logic [31:0] imm,
                         output logic [31:0] fld, output logic e, output logic lat_ok);
    @(negedge clk);
    in_valid = 1'b1; in_fmt = f; in_imm = imm; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat_ok = !out_valid;
    @(negedge clk);
    lat_ok = lat_ok && out_valid;
    fld = out_field;
    e = out_err;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({out_valid, out_err} !== 2'b00 || out_field !== 32'd0 || err_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_state: valid=%b err=%b field=%h cnt=%h, want 0/0/0/0",
               out_valid, out_err, out_field, err_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_encode;
    logic [2:0]  f   [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd0};
    logic [31:0] imm [6] = '{32'hFFFFFFFF, 32'h000007FF, 32'h00000800, 32'hFFFFFFFE, 32'h12345000, 32'h0000001F};
    logic [31:0] exp [6] = '{32'hFFF00000, 32'h7E000F80, 32'h00000080, 32'hFFFFF000, 32'h12345000, 32'h01F00000};
    logic [31:0] fld;
    logic e, lat;
    for (int i = 0; i < 6; i++) begin
      run_req(f[i], imm[i], fld, e, lat);
      tests++;
      if (!lat) begin
        fails++;
        $display("FAIL encode_latency[%0d]: out_valid not exactly 2 cycles after accept", i);
      end
      tests++;
      if (fld !== exp[i] || e !== 1'b0) begin
        fails++;
        $display("FAIL encode[%0d]: field=%h err=%b, want %h err=0", i, fld, e, exp[i]);
      end
    end
  endtask

  task automatic test_errors;
    logic [2:0]  f   [7] = '{3'd1, 3'd3, 3'd4, 3'd7, 3'd6, 3'd0, 3'd5};
    logic [31:0] imm [7] = '{32'h00000800, 32'h00000003, 32'h12345001, 32'h0, 32'h0, 32'h00000020, 32'h00000001};
    logic [31:0] fld;
    logic e, lat;
    for (int i = 0; i < 7; i++) begin
      run_req(f[i], imm[i], fld, e, lat);
      tests++;
      if (fld !== 32'd0 || e !== 1'b1) begin
        fails++;
        $display("FAIL error[%0d]: field=%h err=%b, want 0 err=1", i, fld, e);
      end
      tests++;
      if (err_cnt !== 16'(i + 1)) begin
        fails++;
        $display("FAIL err_cnt[%0d]: got %0d want %0d", i, err_cnt, i + 1);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] imm [3] = '{32'h00000001, 32'h00000002, 32'hFFFFF800};
    logic [31:0] exp [3] = '{32'h00100000, 32'h00200000, 32'h80000000};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        tests++;
        if (out_valid !== 1'b1 || out_field !== exp[i-2]) begin
          fails++;
          $display("FAIL b2b_out[%0d]: valid=%b field=%h want 1 %h", i - 2, out_valid, out_field, exp[i-2]);
        end
      end
      if (i < 3) begin
        tests++;
        if (in_ready !== 1'b1) begin
          fails++;
          $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready);
        end
        in_valid = 1'b1; in_fmt = 3'd1; in_imm = imm[i];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [31:0] fa = 32'h00100000;
    logic [31:0] fb = 32'hABCDE000;
    logic [31:0] fc = 32'hFE000F80;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_fmt = 3'd1; in_imm = 32'h1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_first_ready: got %b want 1", in_ready);
    end
    in_fmt = 3'd4; in_imm = 32'hABCDE000;
    @(negedge clk);
    in_fmt = 3'd2; in_imm = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_field !== fa) begin
        fails++;
        $display("FAIL bp_stall[%0d]: in_ready=%b valid=%b field=%h want 0 1 %h",
                 i, in_ready, out_valid, out_field, fa);
      end
      if (i < 2) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_field !== fb) begin
      fails++;
      $display("FAIL bp_second: valid=%b field=%h want 1 %h", out_valid, out_field, fb);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_field !== fc) begin
      fails++;
      $display("FAIL bp_third: valid=%b field=%h want 1 %h", out_valid, out_field, fc);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_drained: valid=%b want 0", out_valid);
    end
  endtask

  task automatic stream_errors(input int n);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_fmt = 3'd7; in_imm = 32'd0;
    repeat (n) @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_saturation;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    tests++;
    if (err_cnt !== 16'd0) begin
      fails++;
      $display("FAIL clr: got %h want 0000", err_cnt);
    end
    stream_errors(65534);
    tests++;
    if (err_cnt !== 16'hFFFE) begin
      fails++;
      $display("FAIL count_fffe: got %h want fffe", err_cnt);
    end
    stream_errors(1);
    tests++;
    if (err_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL count_ffff: got %h want ffff", err_cnt);
    end
    stream_errors(1);
    tests++;
    if (err_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL saturate: got %h want ffff", err_cnt);
    end
    // Error result sits in S2 while err_clr is raised for its transfer edge.
    @(negedge clk);
    in_valid = 1'b1; in_fmt = 3'd6;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    err_clr = 1'b1;
    tests++;
    if (out_valid !== 1'b1 || out_err !== 1'b1) begin
      fails++;
      $display("FAIL clr_setup: valid=%b err=%b want 1 1", out_valid, out_err);
    end
    @(negedge clk);
    err_clr = 1'b0;
    tests++;
    if (err_cnt !== 16'd0) begin
      fails++;
      $display("FAIL clr_priority: got %h want 0000", err_cnt);
    end
  endtask

  task automatic test_reset_flight;
    int seen = 0;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_fmt = 3'd1; in_imm = 32'h5;
    @(negedge clk);
    in_imm = 32'h6;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || out_field !== 32'd0 || err_cnt !== 16'd0) begin
      fails++;
      $display("FAIL flight_reset: valid=%b field=%h cnt=%h want 0 0 0", out_valid, out_field, err_cnt);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL flight_discard: %0d results emitted, want 0", seen);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flight_ready: got %b want 1", in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_reset_flight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imm_pack.md
IMM_PACK -- requirements
Module: imm_pack

Interface
REQ-001 SHALL have ports, in order: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-002 SHALL have in_valid in 1, request valid; in_ready out 1, request accepted when in_valid & in_ready at clk edge.
REQ-003 SHALL have in_fmt in 3, format code: 0 ITYPE_SHAMT, 1 ITYPE, 2 STYPE, 3 BTYPE, 4 UTYPE, 5 JTYPE; 6 and 7 are illegal.
REQ-004 SHALL have in_imm in 32, signed byte-offset/immediate value to encode.
REQ-005 SHALL have out_valid out 1 and out_ready in 1; a result transfers when both are high at clk edge.
REQ-006 SHALL have out_field out 32, immediate bits placed at instruction bit positions, all other bits 0.
REQ-007 SHALL have out_err out 1, high when the request was not encodable.
REQ-008 SHALL have err_cnt out 16, count of errored results transferred on the output; err_clr in 1, clears the count.

Function
REQ-009 SHALL be the inverse of the immediate extender: extending out_field under the same format returns in_imm whenever out_err=0.
REQ-010 SHALL be a 2-stage pipeline: S1 registers fmt, imm and the range check; S2 registers out_field and out_err; latency accept->out_valid is 2 cycles.
REQ-011 SHALL advance S2 when !S2.valid | out_ready, and advance S1 into S2 under the same condition.
REQ-012 SHALL drive in_ready = !S1.valid | S1 advancing, combinationally; with out_ready held high, throughput is 1 request/cycle.
REQ-013 SHALL hold out_field/out_err stable while out_valid & !out_ready; no request is dropped or duplicated.
REQ-014 ITYPE_SHAMT: legal iff imm[31:5]==0; field[24:20]=imm[4:0].
REQ-015 ITYPE: legal iff imm[31:11] are all equal; field[31:20]=imm[11:0].
REQ-016 STYPE: legality as ITYPE; field[31:25]=imm[11:5], field[11:7]=imm[4:0].
REQ-017 BTYPE: legal iff imm[0]==0 and imm[31:12] are all equal; field[31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
REQ-018 UTYPE: legal iff imm[11:0]==0; field[31:12]=imm[31:12].
REQ-019 JTYPE: legal iff imm[0]==0 and imm[31:20] are all equal; field[31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
REQ-020 Illegal fmt or failed legality SHALL give out_err=1 and out_field=0.
REQ-021 err_cnt SHALL increment by 1 on each output transfer with out_err=1, and SHALL saturate at 0xFFFF.
REQ-022 err_clr SHALL take priority over a same-cycle increment; err_cnt becomes 0.

Reset
REQ-023 rst SHALL clear S1/S2 valid; out_valid=0, out_field=0, out_err=0, err_cnt=0 on the next edge.
REQ-024 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-025 rst mid-operation SHALL discard all in-flight requests; no result is emitted for them.

Verification
REQ-026 ITYPE in_imm=0xFFFFFFFF, out_ready=1 -> 2 cycles later out_field=0xFFF00000, out_err=0.
REQ-027 STYPE 0x000007FF -> 0x7E000F80; ITYPE 0x00000800 -> out_err=1, out_field=0, err_cnt=1.
REQ-028 BTYPE 0x00000800 -> 0x00000080; BTYPE 0x00000003 -> out_err=1; JTYPE 0xFFFFFFFE -> 0xFFFFF000; UTYPE 0x12345000 -> 0x12345000; UTYPE 0x12345001 -> out_err=1; fmt=7 -> out_err=1.
REQ-029 Backpressure: 3 back-to-back requests with out_ready=0 -> in_ready drops after 2 accepted, 3rd held; out_ready=1 -> all 3 results emitted in order on consecutive cycles, out_field stable while stalled.
REQ-030 err_cnt preloaded to 0xFFFF -> a further error keeps it at 0xFFFF; err_clr coincident with an error transfer -> 0; rst asserted with 2 in flight -> out_valid=0 next cycle and nothing emitted afterward.
